// File: rtl/ir_cursor_ctrl.sv
// rtl/ir_cursor_ctrl.sv - IR remote command to cursor/selection controller with hold-off lock-out
// Optional wrap-around at the ends of the cursor range: define IR_CURSOR_WRAP_EN.
module ir_cursor_ctrl #(
    parameter int N_POS   = 8,
    parameter int POS_W   = 3,
    parameter int HOLDOFF = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cdleft,
    input  logic             cdright,
    input  logic             cdsel,
    input  logic             cdrst,
    output logic [POS_W-1:0] pos,
    output logic [N_POS-1:0] pos_onehot,
    output logic             sel_valid,
    output logic [POS_W-1:0] sel_pos,
    output logic             sel_pulse,
    output logic             busy
);

    localparam int TW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [TW-1:0]    HOLD_LOAD = TW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
    localparam logic [POS_W-1:0] LAST      = POS_W'(N_POS - 1);

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
    typedef enum logic [1:0] {C_CLR, C_SEL, C_LEFT, C_RIGHT} cmd_t;

    state_t          state, state_nxt;
    cmd_t            cmd_r, ev_cmd;
    logic [3:0]      cmd_q, cmd_p, ev;
    logic [TW-1:0]   timer;
    logic [POS_W-1:0] pos_nxt;

    // Bit order {clear, select, left, right}; stored active-high, so reset value means "all released"
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_q <= '0;
            cmd_p <= '0;
        end else begin
            cmd_q <= ~{cdrst, cdsel, cdleft, cdright};
            cmd_p <= cmd_q;
        end
    end

    assign ev = cmd_q & ~cmd_p;

    always_comb begin
        ev_cmd = C_RIGHT;
        if (ev[3])      ev_cmd = C_CLR;
        else if (ev[2]) ev_cmd = C_SEL;
        else if (ev[1]) ev_cmd = C_LEFT;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|ev) state_nxt = EXEC;
            EXEC:    state_nxt = (HOLDOFF == 0) ? IDLE : HOLD;
            HOLD:    if (timer == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= '0;
            cmd_r <= C_CLR;
        end else begin
            if (state == IDLE && |ev)
                cmd_r <= ev_cmd;
            if (state == EXEC)
                timer <= HOLD_LOAD;
            else if (state == HOLD && timer != '0)
                timer <= timer - TW'(1);
        end
    end

    // Cursor arithmetic is clamped to 0..N_POS-1 so unused codes of POS_W are never reached
    always_comb begin
        pos_nxt = pos;
        if (state == EXEC) begin
            case (cmd_r)
                C_CLR: pos_nxt = '0;
                C_LEFT: begin
                    if (pos == '0)
`ifdef IR_CURSOR_WRAP_EN
                        pos_nxt = LAST;
`else
                        pos_nxt = '0;
`endif
                    else
                        pos_nxt = pos - POS_W'(1);
                end
                C_RIGHT: begin
                    if (pos >= LAST)
`ifdef IR_CURSOR_WRAP_EN
                        pos_nxt = '0;
`else
                        pos_nxt = LAST;
`endif
                    else
                        pos_nxt = pos + POS_W'(1);
                end
                default: pos_nxt = pos;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos        <= '0;
            pos_onehot <= N_POS'(1);
            sel_valid  <= 1'b0;
            sel_pos    <= '0;
            sel_pulse  <= 1'b0;
        end else begin
            pos        <= pos_nxt;
            pos_onehot <= N_POS'(1) << pos_nxt;
            sel_pulse  <= (state == EXEC) && (cmd_r == C_SEL);
            if (state == EXEC && cmd_r == C_SEL) begin
                sel_pos   <= pos;
                sel_valid <= 1'b1;
            end else if (state == EXEC && cmd_r == C_CLR) begin
                sel_pos   <= '0;
                sel_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ir_cursor_ctrl.sv
// tb/tb_ir_cursor_ctrl.sv - directed self-checking bench for ir_cursor_ctrl (N_POS=8, HOLDOFF=4)
module tb_ir_cursor_ctrl;

    localparam int N_POS   = 8;
    localparam int POS_W   = 3;
    localparam int HOLDOFF = 4;
`ifdef IR_CURSOR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif
    localparam logic [3:0] A_CLR   = 4'b1000;
    localparam logic [3:0] A_SEL   = 4'b0100;
    localparam logic [3:0] A_LEFT  = 4'b0010;
    localparam logic [3:0] A_RIGHT = 4'b0001;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cdleft = 1'b1, cdright = 1'b1, cdsel = 1'b1, cdrst = 1'b1;
    logic [POS_W-1:0] pos, sel_pos;
    logic [N_POS-1:0] pos_onehot;
    logic             sel_valid, sel_pulse, busy;

    int checks = 0;
    int errors = 0;

    ir_cursor_ctrl #(.N_POS(N_POS), .POS_W(POS_W), .HOLDOFF(HOLDOFF)) dut (
        .clk(clk), .rst(rst),
        .cdleft(cdleft), .cdright(cdright), .cdsel(cdsel), .cdrst(cdrst),
        .pos(pos), .pos_onehot(pos_onehot), .sel_valid(sel_valid),
        .sel_pos(sel_pos), .sel_pulse(sel_pulse), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] act);
        {cdrst, cdsel, cdleft, cdright} = ~act;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
        end
        tick();
    endtask

    task automatic run_cmd(input logic [3:0] act);
        drive(act);
        tick();
        drive(4'b0000);
        tick();
        tick();
        wait_idle();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(4'b0000);
        repeat (3) tick();
        checks++;
        if ({pos, pos_onehot, sel_valid, sel_pos, sel_pulse, busy} !== {3'd0, 8'h01, 1'b0, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: pos=%0d onehot=%h sv=%b sp=%0d pulse=%b busy=%b, required 0 01 0 0 0 0",
                     pos, pos_onehot, sel_valid, sel_pos, sel_pulse, busy);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_right_timing();
        drive(A_RIGHT);
        tick();
        drive(4'b0000);
        checks++;
        if ({busy, pos} !== {1'b0, 3'd0}) begin
            errors++;
            $display("FAIL right_t0: busy=%b pos=%0d, required 0 0", busy, pos);
        end
        tick();
        checks++;
        if ({busy, pos} !== {1'b1, 3'd0}) begin
            errors++;
            $display("FAIL right_t1: busy=%b pos=%0d, required 1 0", busy, pos);
        end
        tick();
        checks++;
        if ({busy, pos, pos_onehot} !== {1'b1, 3'd1, 8'b0000_0010}) begin
            errors++;
            $display("FAIL right_t2: busy=%b pos=%0d onehot=%b, required 1 1 00000010", busy, pos, pos_onehot);
        end
        repeat (3) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL right_busy_last: busy=%b, required 1", busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL right_busy_end: busy=%b, required 0", busy);
        end
        tick();
    endtask

    task automatic test_holdoff_drop();
        drive(A_RIGHT);
        tick();
        drive(4'b0000);
        tick();
        tick();
        drive(A_RIGHT);
        tick();
        drive(4'b0000);
        wait_idle();
        tick();
        checks++;
        if (pos !== 3'd2) begin
            errors++;
            $display("FAIL drop_in_hold: pos=%0d, required 2", pos);
        end
        drive(A_RIGHT);
        tick();
        drive(4'b0000);
        tick();
        tick();
        drive(A_RIGHT);
        wait_idle();
        repeat (3) tick();
        drive(4'b0000);
        tick();
        checks++;
        if ({pos, busy} !== {3'd3, 1'b0}) begin
            errors++;
            $display("FAIL held_through_hold: pos=%0d busy=%b, required 3 0", pos, busy);
        end
        run_cmd(A_RIGHT);
        checks++;
        if ({pos, pos_onehot} !== {3'd4, 8'h10}) begin
            errors++;
            $display("FAIL after_hold: pos=%0d onehot=%h, required 4 10", pos, pos_onehot);
        end
    endtask

    task automatic test_wrap();
        logic [POS_W-1:0] exp_pos;
        logic [N_POS-1:0] exp_oh;
        run_cmd(A_CLR);
        run_cmd(A_LEFT);
        exp_pos = WRAP ? 3'd7 : 3'd0;
        exp_oh  = WRAP ? 8'h80 : 8'h01;
        checks++;
        if ({pos, pos_onehot} !== {exp_pos, exp_oh}) begin
            errors++;
            $display("FAIL left_at_0: pos=%0d onehot=%h, required %0d %h", pos, pos_onehot, exp_pos, exp_oh);
        end
        if (!WRAP) repeat (7) run_cmd(A_RIGHT);
        checks++;
        if ({pos, pos_onehot} !== {3'd7, 8'h80}) begin
            errors++;
            $display("FAIL reach_7: pos=%0d onehot=%h, required 7 80", pos, pos_onehot);
        end
        run_cmd(A_RIGHT);
        exp_pos = WRAP ? 3'd0 : 3'd7;
        exp_oh  = WRAP ? 8'h01 : 8'h80;
        checks++;
        if ({pos, pos_onehot} !== {exp_pos, exp_oh}) begin
            errors++;
            $display("FAIL right_at_7: pos=%0d onehot=%h, required %0d %h", pos, pos_onehot, exp_pos, exp_oh);
        end
    endtask

    task automatic test_select();
        run_cmd(A_CLR);
        repeat (5) run_cmd(A_RIGHT);
        checks++;
        if (pos !== 3'd5) begin
            errors++;
            $display("FAIL sel_setup: pos=%0d, required 5", pos);
        end
        drive(A_SEL);
        tick();
        drive(4'b0000);
        tick();
        checks++;
        if ({sel_pulse, sel_valid} !== 2'b00) begin
            errors++;
            $display("FAIL sel_t1: pulse=%b valid=%b, required 0 0", sel_pulse, sel_valid);
        end
        tick();
        checks++;
        if ({sel_pulse, sel_valid, sel_pos, pos} !== {1'b1, 1'b1, 3'd5, 3'd5}) begin
            errors++;
            $display("FAIL sel_t2: pulse=%b valid=%b sel_pos=%0d pos=%0d, required 1 1 5 5",
                     sel_pulse, sel_valid, sel_pos, pos);
        end
        tick();
        checks++;
        if ({sel_pulse, sel_valid} !== 2'b01) begin
            errors++;
            $display("FAIL sel_t3: pulse=%b valid=%b, required 0 1", sel_pulse, sel_valid);
        end
        wait_idle();
        run_cmd(A_CLR);
        checks++;
        if ({pos, pos_onehot, sel_valid, sel_pos} !== {3'd0, 8'h01, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL clear: pos=%0d onehot=%h valid=%b sel_pos=%0d, required 0 01 0 0",
                     pos, pos_onehot, sel_valid, sel_pos);
        end
    endtask

    task automatic test_priority();
        repeat (3) run_cmd(A_RIGHT);
        run_cmd(A_SEL | A_LEFT);
        checks++;
        if ({pos, sel_valid, sel_pos} !== {3'd3, 1'b1, 3'd3}) begin
            errors++;
            $display("FAIL sel_over_left: pos=%0d valid=%b sel_pos=%0d, required 3 1 3", pos, sel_valid, sel_pos);
        end
        drive(A_LEFT);
        repeat (20) tick();
        drive(4'b0000);
        wait_idle();
        checks++;
        if (pos !== 3'd2) begin
            errors++;
            $display("FAIL held_left: pos=%0d, required 2", pos);
        end
        run_cmd(A_CLR | A_SEL);
        checks++;
        if ({pos, sel_valid, sel_pos} !== {3'd0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL clr_over_sel: pos=%0d valid=%b sel_pos=%0d, required 0 0 0", pos, sel_valid, sel_pos);
        end
    endtask

    task automatic test_reset_mid();
        run_cmd(A_RIGHT);
        run_cmd(A_RIGHT);
        run_cmd(A_SEL);
        drive(A_RIGHT);
        tick();
        drive(4'b0000);
        tick();
        tick();
        tick();
        checks++;
        if ({busy, sel_valid, sel_pos, pos} !== {1'b1, 1'b1, 3'd2, 3'd3}) begin
            errors++;
            $display("FAIL pre_reset: busy=%b valid=%b sel_pos=%0d pos=%0d, required 1 1 2 3",
                     busy, sel_valid, sel_pos, pos);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({pos, pos_onehot, sel_valid, sel_pos, sel_pulse, busy} !== {3'd0, 8'h01, 1'b0, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: pos=%0d onehot=%h sv=%b sp=%0d pulse=%b busy=%b, required 0 01 0 0 0 0",
                     pos, pos_onehot, sel_valid, sel_pos, sel_pulse, busy);
        end
        tick();
        rst = 1'b1;
        tick();
        run_cmd(A_RIGHT);
        checks++;
        if ({pos, pos_onehot} !== {3'd1, 8'h02}) begin
            errors++;
            $display("FAIL post_reset_cmd: pos=%0d onehot=%h, required 1 02", pos, pos_onehot);
        end
    endtask

    initial begin
        test_reset();
        test_right_timing();
        test_holdoff_drop();
        test_wrap();
        test_select();
        test_priority();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
